// File: rtl/source_c_pkg.sv
// source_c_pkg: shared opcodes, field widths and beat types for the outer
// TileLink C-channel transmitter (source_c) and its output queue.
package source_c_pkg;

  localparam logic [2:0] PROBE_ACK      = 3'd4;
  localparam logic [2:0] PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] RELEASE        = 3'd6;
  localparam logic [2:0] RELEASE_DATA   = 3'd7;

  localparam int TAG_W     = 17;
  localparam int SET_W     = 10;
  localparam int WAY_W     = 3;
  localparam int SRC_W     = 6;
  localparam int BEAT_W    = 3;
  localparam int LINE_SIZE = 6;
  localparam int OP_W      = 3;
  localparam int PARAM_W   = 3;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = TAG_W + SET_W + LINE_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_READ
  } state_e;

  // Message header travelling alongside each banked-store read.
  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [PARAM_W-1:0] param;
    logic [SRC_W-1:0]   source;
    logic [ADDR_W-1:0]  address;
  } c_hdr_t;

  // One beat of the outer C channel as held in the output queue.
  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [PARAM_W-1:0] param;
    logic [SRC_W-1:0]   source;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  data;
  } c_beat_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [SET_W-1:0] set);
    return {tag, set, {LINE_SIZE{1'b0}}};
  endfunction

  function automatic c_beat_t make_beat(input c_hdr_t hdr, input logic [DATA_W-1:0] data);
    c_beat_t b;
    b.opcode  = hdr.opcode;
    b.param   = hdr.param;
    b.source  = hdr.source;
    b.address = hdr.address;
    b.data    = data;
    return b;
  endfunction

endpackage

// File: rtl/source_c_queue.sv
// source_c_queue: DEPTH-entry FIFO of C-channel beats with registered head.
// A push becomes visible at the head the cycle after it is written (no
// flow-through). The caller guarantees a push never arrives when full.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i/push_data_i write one beat
//   pop_i              remove the head beat (ignored when empty)
//   head_o/valid_o     head entry and non-empty flag
//   count_o            current occupancy
module source_c_queue
  import source_c_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  c_beat_t          push_data_i,
  input  logic             pop_i,
  output c_beat_t          head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  c_beat_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (do_pop) rd_q <= ptr_inc(rd_q);
      count_q <= count_d;
    end
  end

  // Storage is data only; emptiness is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/source_c.sv
// source_c: outer-side TileLink C-channel transmitter of an inclusive cache
// bank. Takes one Release/ReleaseData/ProbeAck/ProbeAckData command at a time,
// reads the 8-beat line from the banked store for data-bearing opcodes and
// sends the message through a credit-managed queue onto the outer C channel.
// Ports:
//   clock, reset              clock, asynchronous active-low reset
//   io_req_*                  command from the scheduler
//   io_bs_adr_*               banked-store read request (beat per fire)
//   io_bs_dat_data            read data, BS_LAT cycles after each fire
//   io_c_*                    outer C channel
//   io_busy                   command, read or queued beat outstanding
// QDEPTH must be at least BS_LAT+1 to sustain one beat per cycle.
module source_c
  import source_c_pkg::*;
#(
  parameter int BS_LAT = 2,
  parameter int QDEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_req_ready,
  input  logic                io_req_valid,
  input  logic [OP_W-1:0]     io_req_bits_opcode,
  input  logic [PARAM_W-1:0]  io_req_bits_param,
  input  logic [SRC_W-1:0]    io_req_bits_source,
  input  logic [TAG_W-1:0]    io_req_bits_tag,
  input  logic [SET_W-1:0]    io_req_bits_set,
  input  logic [WAY_W-1:0]    io_req_bits_way,
  input  logic                io_bs_adr_ready,
  output logic                io_bs_adr_valid,
  output logic                io_bs_adr_bits_noop,
  output logic [WAY_W-1:0]    io_bs_adr_bits_way,
  output logic [SET_W-1:0]    io_bs_adr_bits_set,
  output logic [BEAT_W-1:0]   io_bs_adr_bits_beat,
  output logic                io_bs_adr_bits_mask,
  input  logic [DATA_W-1:0]   io_bs_dat_data,
  input  logic                io_c_ready,
  output logic                io_c_valid,
  output logic [OP_W-1:0]     io_c_bits_opcode,
  output logic [PARAM_W-1:0]  io_c_bits_param,
  output logic [2:0]          io_c_bits_size,
  output logic [SRC_W-1:0]    io_c_bits_source,
  output logic [ADDR_W-1:0]   io_c_bits_address,
  output logic [DATA_W-1:0]   io_c_bits_data,
  output logic                io_c_bits_corrupt,
  output logic                io_busy
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int SUM_W = ((CNT_W > 3) ? CNT_W : 3) + 1;

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [2:0]          inflight_q, inflight_d;
  logic [BS_LAT-1:0]   vld_p;
  c_hdr_t              hdr_p [BS_LAT];

  logic [OP_W-1:0]     op_q;
  logic [PARAM_W-1:0]  param_q;
  logic [SRC_W-1:0]    src_q;
  logic [TAG_W-1:0]    tag_q;
  logic [SET_W-1:0]    set_q;
  logic [WAY_W-1:0]    way_q;

  c_hdr_t              hdr_cur;
  c_beat_t             push_beat, head;
  logic [CNT_W-1:0]    occ;
  logic                credit, req_fire, adr_fire, ret_vld, hdr_push, push, pop, q_valid;

  assign io_req_ready = (state_q == S_IDLE);
  assign req_fire     = io_req_ready & io_req_valid;

  // A queue slot is reserved for every read in flight, so returning data
  // (which cannot be stalled) always finds room.
  assign credit   = (SUM_W'(occ) + SUM_W'(inflight_q)) < SUM_W'(QDEPTH);
  assign adr_fire = io_bs_adr_valid & io_bs_adr_ready;
  assign ret_vld  = vld_p[BS_LAT-1];

  // A dataless header waits for the previous message's reads to land so
  // beats leave in command order and never collide with a data push.
  assign hdr_push = (state_q == S_HDR) & credit & (inflight_q == '0);
  assign push     = ret_vld | hdr_push;
  assign pop      = q_valid & io_c_ready;

  assign hdr_cur.opcode  = op_q;
  assign hdr_cur.param   = param_q;
  assign hdr_cur.source  = src_q;
  assign hdr_cur.address = line_addr(tag_q, set_q);

  assign push_beat = ret_vld ? make_beat(hdr_p[BS_LAT-1], io_bs_dat_data)
                             : make_beat(hdr_cur, '0);

  assign io_bs_adr_valid     = (state_q == S_READ) & credit;
  assign io_bs_adr_bits_noop = 1'b0;
  assign io_bs_adr_bits_way  = way_q;
  assign io_bs_adr_bits_set  = set_q;
  assign io_bs_adr_bits_beat = beat_q;
  assign io_bs_adr_bits_mask = 1'b1;

  always_comb begin
    inflight_d = inflight_q;
    case ({adr_fire, ret_vld})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      inflight_q <= '0;
      vld_p      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_fire) state_q <= io_req_bits_opcode[0] ? S_READ : S_HDR;
        S_HDR:  if (hdr_push) state_q <= S_IDLE;
        S_READ: if (adr_fire && (beat_q == '1)) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (adr_fire) beat_q <= beat_q + 1'b1;
      inflight_q <= inflight_d;
      // p0 .. p(BS_LAT-1): read issued -> banked-store data valid
      vld_p[0] <= adr_fire;
      for (int i = 1; i < BS_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) begin
      op_q    <= io_req_bits_opcode;
      param_q <= io_req_bits_param;
      src_q   <= io_req_bits_source;
      tag_q   <= io_req_bits_tag;
      set_q   <= io_req_bits_set;
      way_q   <= io_req_bits_way;
    end
    hdr_p[0] <= hdr_cur;
    for (int i = 1; i < BS_LAT; i++) hdr_p[i] <= hdr_p[i-1];
  end

  source_c_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i (push_beat),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (q_valid),
    .count_o     (occ)
  );

  assign io_c_valid        = q_valid;
  assign io_c_bits_opcode  = head.opcode;
  assign io_c_bits_param   = head.param;
  assign io_c_bits_size    = 3'(LINE_SIZE);
  assign io_c_bits_source  = head.source;
  assign io_c_bits_address = head.address;
  assign io_c_bits_data    = head.data;
  assign io_c_bits_corrupt = 1'b0;

  assign io_busy = (state_q != S_IDLE) | (inflight_q != '0) | q_valid;

endmodule
